// File: rtl/pc_stack_unit.sv
// rtl/pc_stack_unit.sv - program counter and return-address stack for the stack CPU
// Optional fault halt state enabled by defining PC_FAULT_HALT_EN.
module pc_stack_unit #(
    parameter int PC_WIDTH    = 5,
    parameter int STACK_DEPTH = 8,
    parameter int SP_WIDTH    = 3
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                stall,
    input  logic                jmp,
    input  logic                cal,
    input  logic                ret,
    input  logic [PC_WIDTH-1:0] jmp_addr,
    output logic [PC_WIDTH-1:0] pc,
    output logic [SP_WIDTH:0]   depth,
    output logic [PC_WIDTH-1:0] ret_addr,
    output logic                overflow,
    output logic                underflow,
    output logic                halted
);

    localparam logic [SP_WIDTH:0] DEPTH_FULL = (SP_WIDTH+1)'(STACK_DEPTH);
    localparam logic [SP_WIDTH:0] DEPTH_ONE  = (SP_WIDTH+1)'(1);

    logic [PC_WIDTH-1:0] stack [STACK_DEPTH];

    logic [PC_WIDTH-1:0] pc_q;
    logic [PC_WIDTH-1:0] pc_next;
    logic [PC_WIDTH-1:0] pc_inc;
    logic [SP_WIDTH:0]   depth_q;
    logic [SP_WIDTH:0]   depth_next;
    logic [SP_WIDTH-1:0] top_idx;
    logic [SP_WIDTH-1:0] push_idx;
    logic                overflow_q;
    logic                underflow_q;
    logic                push_en;
    logic                ovf_set;
    logic                unf_set;
    logic                run_en;

    assign pc_inc   = pc_q + PC_WIDTH'(1);
    // Low bits of depth-1 address the top entry; wraps correctly when depth is full.
    assign top_idx  = depth_q[SP_WIDTH-1:0] - SP_WIDTH'(1);
    assign push_idx = depth_q[SP_WIDTH-1:0];

`ifdef PC_FAULT_HALT_EN
    typedef enum logic [0:0] {
        RUN    = 1'b0,
        HALTED = 1'b1
    } state_t;

    state_t state_q;
    state_t state_next;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= RUN;
        end else begin
            state_q <= state_next;
        end
    end

    // Enter HALTED on the same edge that raises either fault flag.
    always_comb begin
        state_next = state_q;
        if (state_q == RUN && (ovf_set || unf_set)) begin
            state_next = HALTED;
        end
    end

    assign run_en = (state_q == RUN) && !stall;
    assign halted = (state_q == HALTED);
`else
    assign run_en = !stall;
    assign halted = 1'b0;
`endif

    // Priority: ret > cal > jmp > sequential.
    always_comb begin
        pc_next    = pc_q;
        depth_next = depth_q;
        push_en    = 1'b0;
        ovf_set    = 1'b0;
        unf_set    = 1'b0;
        if (run_en) begin
            if (ret) begin
                if (depth_q != '0) begin
                    pc_next    = stack[top_idx];
                    depth_next = depth_q - DEPTH_ONE;
                end else begin
                    unf_set = 1'b1;
                    pc_next = pc_inc;
                end
            end else if (cal) begin
                if (depth_q != DEPTH_FULL) begin
                    push_en    = 1'b1;
                    depth_next = depth_q + DEPTH_ONE;
                    pc_next    = jmp_addr;
                end else begin
                    ovf_set = 1'b1;
                    pc_next = pc_inc;
                end
            end else if (jmp) begin
                pc_next = jmp_addr;
            end else begin
                pc_next = pc_inc;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pc_q        <= '0;
            depth_q     <= '0;
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            pc_q        <= pc_next;
            depth_q     <= depth_next;
            overflow_q  <= overflow_q | ovf_set;
            underflow_q <= underflow_q | unf_set;
        end
    end

    // Stack contents need no reset; depth alone decides what is valid.
    always_ff @(posedge clk) begin
        if (!rst && push_en) begin
            stack[push_idx] <= pc_inc;
        end
    end

    assign pc        = pc_q;
    assign depth     = depth_q;
    assign ret_addr  = (depth_q == '0) ? '0 : stack[top_idx];
    assign overflow  = overflow_q;
    assign underflow = underflow_q;

endmodule

// File: doc/pc_stack_unit.md
Name: pc_stack_unit

Overview:
Program counter and return-address stack for the stack CPU. It sits directly downstream of the instruction decoder and consumes the decoder's jmp/cal/ret strobes and jmp_addr. It produces the instruction address for the next fetch, and that fetch feeds the decoder again in the following cycle. It owns the call stack and reports stack faults.

Parameters:
PC_WIDTH, 5, width of program counter and jump/return addresses
STACK_DEPTH, 8, number of return-address entries (power of two, >=2)
SP_WIDTH, 3, log2(STACK_DEPTH); sp field width

Ports:
clk  input  1  system clock, all state updates on rising edge
rst  input  1  synchronous active-high reset
stall  input  1  1 = hold all state this cycle (pc, stack, flags unchanged)
jmp  input  1  decoder jump strobe
cal  input  1  decoder call strobe (decoder also drives jmp=1 with it)
ret  input  1  decoder return strobe
jmp_addr  input  PC_WIDTH  jump/call target from decoder
pc  output  PC_WIDTH  current instruction address (registered)
depth  output  SP_WIDTH+1  number of valid stack entries, 0..STACK_DEPTH
ret_addr  output  PC_WIDTH  top-of-stack value, combinational; 0 when depth==0
overflow  output  1  sticky: call attempted with stack full
underflow  output  1  sticky: return attempted with stack empty
halted  output  1  1 = fault halt state (see Optional Feature); tied 0 when feature absent

Behaviour:
- One clock, synchronous active-high reset. clk and rst only; no async paths.
- Reset: pc=0, depth=0, overflow=0, underflow=0, halted=0, FSM=RUN. Stack array contents are don't-care; ret_addr reads 0 because depth==0.
- Control is sampled on the rising edge. The new pc is visible 1 cycle after the strobe. The decoder is combinational off the fetched instruction, so a taken branch costs no bubble.
- stall=1: no state changes at all; strobes are ignored.
- Per-cycle priority when not stalled and FSM=RUN: ret > cal > jmp > sequential.
  - ret, depth>0: pc <= stack[depth-1]; depth <= depth-1.
  - ret, depth==0: underflow <= 1; pc <= pc+1; depth unchanged.
  - cal, depth<STACK_DEPTH: stack[depth] <= pc+1 (wrapped); depth <= depth+1; pc <= jmp_addr.
  - cal, depth==STACK_DEPTH: overflow <= 1; no push; call not taken; pc <= pc+1.
  - jmp alone: pc <= jmp_addr; stack unchanged.
  - none: pc <= pc+1.
- Arithmetic: pc+1 is modulo 2^PC_WIDTH, so 31 -> 0 at default width. A pushed return address wraps the same way.
- Illegal combination ret&cal: ret wins and cal is ignored. This is not flagged.
- Flags are sticky until rst and are never cleared by later legal operations.
- Reset asserted mid-call or mid-return overrides everything in that cycle.

Optional Feature:
Macro PC_FAULT_HALT_EN.
- Defined: the FSM has two states, RUN and HALTED.
  - RUN -> HALTED on the same edge that sets overflow or underflow.
  - In HALTED: pc frozen at the value computed on the faulting edge (pc+1), all strobes ignored, halted=1.
  - Only rst exits HALTED. stall has no effect in HALTED.
- Undefined: there is no HALTED state and halted is tied to 0. Faults only set sticky flags and execution continues as described in Behaviour.

Test Plan:
- Reset then 33 idle cycles -> pc counts 0..31, then wraps to 0, then 1; depth=0, flags 0.
- At pc=3, cal=1 jmp=1 jmp_addr=20 -> next pc=20, depth=1, ret_addr=4. Then ret=1 -> pc=4, depth=0.
- 8 nested calls from pc=0 with jmp_addr=10 each -> depth=8, ret_addr=11. A 9th call -> overflow=1, depth stays 8, pc=11.
  - With PC_FAULT_HALT_EN: halted=1 and pc stays 11 for 5+ cycles despite jmp strobes.
- ret with depth=0 at pc=7 -> underflow=1, pc=8. Without the macro, the following jmp_addr=2 jmp is taken (pc=2).
- stall=1 held for 3 cycles together with cal=1, jmp_addr=15 at pc=5 -> pc stays 5, depth 0. Release stall with strobes still high -> pc=15, ret_addr=6.
- ret=1 and cal=1 together with depth=1, top=9 -> pc=9, depth=0, no push.
  - Also: assert rst during a cal cycle -> pc=0, depth=0.
